// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: sequences the PC, reads the
// instruction (and mvi immediate) and hands it to the core.
module instr_fetch_unit #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int MEM_LAT  = 1,
  parameter int END_ADDR = 63
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] MemData,
  input  logic              Done,
  input  logic [1:0]        Ciclo,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] DIN,
  output logic              Go,
  output logic [ADDR_W-1:0] PC,
  output logic              Halted,
  output logic              Err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_I,
    FETCH_IMM,
    READY,
    HALT
  } state_t;

  localparam logic [1:0] LAT = 2'(MEM_LAT);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  state_t state;
  state_t state_n;

  logic [1:0]        cnt;
  logic [1:0]        cnt_n;
  logic [ADDR_W-1:0] pc_n;
  logic [ADDR_W-1:0] addr_n;
  logic [ADDR_W-1:0] pc_p1;
  logic [ADDR_W-1:0] pc_p2;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] instr_n;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] imm_n;
  logic              go_n;
  logic              halted_n;
  logic              err_n;
  logic              is_mvi;
  logic              last;
  logic              at_end;

  assign pc_p1  = PC + ONE;
  assign pc_p2  = PC + TWO;
  assign is_mvi = (instr[8:6] == 3'b001);
  assign last   = (cnt == LAT);

  // The last instruction is the one at END_ADDR, or an mvi whose
  // immediate word sits there.
  assign at_end = (int'(PC) == END_ADDR) ||
                  (is_mvi && (int'(pc_p1) == END_ADDR));

  // The immediate is only exposed in the core's second time-step.
  always_comb begin
    DIN = instr;
    if (state == READY && is_mvi && Ciclo == 2'b01)
      DIN = imm;
  end

  // Next-state logic and next values of every register.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pc_n     = PC;
    addr_n   = Addr;
    instr_n  = instr;
    imm_n    = imm;
    halted_n = Halted;
    err_n    = Err | (Done && state != READY);
    unique case (state)
      IDLE: begin
        addr_n = PC;
        cnt_n  = 2'd0;
        if (Run)
          state_n = FETCH_I;
      end
      FETCH_I: begin
        addr_n = PC;
        if (last) begin
          instr_n = MemData;
          cnt_n   = 2'd0;
          if (MemData[8:6] == 3'b001) begin
            addr_n  = pc_p1;
            state_n = FETCH_IMM;
          end else begin
            state_n = READY;
          end
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      FETCH_IMM: begin
        addr_n = pc_p1;
        if (last) begin
          imm_n   = MemData;
          cnt_n   = 2'd0;
          state_n = READY;
        end else begin
          cnt_n = cnt + 2'd1;
        end
      end
      READY: begin
        if (Done) begin
          if (at_end) begin
            halted_n = 1'b1;
            state_n  = HALT;
          end else begin
            pc_n    = is_mvi ? pc_p2 : pc_p1;
            addr_n  = pc_n;
            cnt_n   = 2'd0;
            state_n = Run ? FETCH_I : IDLE;
          end
        end
      end
      HALT: begin
        halted_n = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    go_n = (state_n == READY);
  end

  // State and datapath registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      PC     <= '0;
      Addr   <= '0;
      instr  <= '0;
      imm    <= '0;
      Go     <= 1'b0;
      Halted <= 1'b0;
      Err    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      PC     <= pc_n;
      Addr   <= addr_n;
      instr  <= instr_n;
      imm    <= imm_n;
      Go     <= go_n;
      Halted <= halted_n;
      Err    <= err_n;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream stage of the processor core. Sequences the program counter, drives the synchronous instruction memory, and captures the instruction word. For mvi it also captures the immediate word that follows. It presents DIN to the core and releases the core to execute with Go. It advances the PC when the core reports Done.

Parameters:
ADDR_W, 6, program counter / memory address width
DATA_W, 16, instruction and memory data width
MEM_LAT, 1, cycles from Addr change to valid MemData (1..3)
END_ADDR, 63, address whose instruction completion halts fetch

Ports:
Clock  input  1  single system clock, rising edge
Resetn  input  1  asynchronous, active-low reset
Run  input  1  level; enables fetching
MemData  input  DATA_W  read data from instruction memory
Done  input  1  core pulse: current instruction complete
Ciclo  input  2  core time-step counter
Addr  output  ADDR_W  memory read address
DIN  output  DATA_W  data presented to the core
Go  output  1  instruction (and immediate) valid; core may advance
PC  output  ADDR_W  address of current instruction
Halted  output  1  fetch stopped at END_ADDR
Err  output  1  sticky: Done seen while Go=0

Behaviour:
- Reset is asynchronous and active-low. On Resetn=0 the block immediately enters IDLE and sets:
  - PC=0, Addr=0
  - instruction register InstrR=0, immediate register ImmR=0
  - Go=0, Halted=0, Err=0
- States: IDLE, FETCH_I, FETCH_IMM, READY, HALT.
- IDLE:
  - Addr=PC, Go=0.
  - If Run=1 then FETCH_I.
- FETCH_I:
  - Addr=PC. A wait counter runs MEM_LAT cycles; on the last cycle InstrR<=MemData.
  - If MemData[8:6]==3'b001 (mvi), go to FETCH_IMM. Otherwise go to READY.
- FETCH_IMM:
  - Addr=PC+1, wrapping mod 2^ADDR_W.
  - After MEM_LAT cycles, ImmR<=MemData, then READY.
- READY:
  - Go=1, Addr holds its last value.
  - DIN = ImmR when the opcode is mvi and Ciclo==2'b01; otherwise DIN = InstrR.
  - In all other states DIN = InstrR.
- Done=1 in READY completes the instruction, registered on the same edge:
  - If PC==END_ADDR, or for mvi PC+1==END_ADDR: Halted<=1, Go<=0, state HALT; PC is not updated.
  - Otherwise PC<=PC+1, or PC+2 for mvi, wrapping mod 2^ADDR_W. Next state is FETCH_I if Run=1, else IDLE.
- HALT: Go=0, Halted=1. Leaves only through reset.
- Run=0 during FETCH_I or FETCH_IMM: the current fetch completes and the block still enters READY. Run is sampled only at Done and in IDLE.
- Done=1 while not in READY: ignored for PC purposes, sets Err=1. Err clears only on reset.
- Latency, non-mvi: Go asserts MEM_LAT+1 cycles after entering FETCH_I.
- Latency, mvi: Go asserts 2*MEM_LAT+2 cycles after entering FETCH_I.
- Simultaneous Done and Resetn=0: reset wins.
- Ciclo is used only for DIN selection.

Test Plan:
- Reset then Run=1, mem[0]=16'h0008 (mv R1,R0), MEM_LAT=1 -> Go=1 two cycles after leaving IDLE, DIN=0x0008. After a Done pulse -> PC=1, Addr=1.
- mem[4]=16'h0048 (mvi R1), mem[5]=16'h1234 -> DIN=0x0048 at Ciclo=0 and 0x1234 at Ciclo=1. After Done -> PC=6.
- END_ADDR=3, sequential non-mvi program -> Done at PC=3 gives Halted=1, Go=0, PC stays 3. Further Done pulses set Err=1 and PC is unchanged.
- PC=63, ADDR_W=6, mvi at 63 with END_ADDR=10 -> immediate fetched from Addr=0. After Done -> PC=1.
- Done pulsed in FETCH_I -> Err=1, PC unchanged, fetch completes normally.
- Resetn=0 asserted mid-FETCH_IMM, asynchronously -> PC=0, Go=0, Err=0, state IDLE before the next edge. Release with Run=1 -> refetch from 0. Repeat with MEM_LAT=3 to confirm Go delay is 4 cycles for non-mvi and 8 cycles for mvi.
